// File: rtl/csr_file_if.sv
// -----------------------------------------------------------------------------
// csr_file_if
// Bundles the decode-stage <-> CSR-file signals.
//   master : decode/next-PC side (drives requests, consumes read data/vectors)
//   slave  : csr_file side
// Signals:
//   retire      instruction commits this cycle (gates all CSR writes, minstret)
//   pc          PC of current instruction (captured into mepc on trap entry)
//   csr_raddr   combinational read address      csr_rdata  read data
//   csr_waddr1  port-1 write address            csr_wdata1 port-1 write data
//   csr_wen1    port-1 write enable             csr_wen2   trap entry (ecall)
//   mret        trap return
//   mtvec_o     current mtvec                   mepc_o     current mepc
// -----------------------------------------------------------------------------
interface csr_file_if;
    logic        retire;
    logic [31:0] pc;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [11:0] csr_waddr1;
    logic [31:0] csr_wdata1;
    logic        csr_wen1;
    logic        csr_wen2;
    logic        mret;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;

    modport master (
        output retire, pc, csr_raddr, csr_waddr1, csr_wdata1,
               csr_wen1, csr_wen2, mret,
        input  csr_rdata, mtvec_o, mepc_o
    );

    modport slave (
        input  retire, pc, csr_raddr, csr_waddr1, csr_wdata1,
               csr_wen1, csr_wen2, mret,
        output csr_rdata, mtvec_o, mepc_o
    );
endinterface

// File: rtl/csr_file.sv
// -----------------------------------------------------------------------------
// csr_file
// Machine-mode CSR register file. Zero-latency read port, one general write
// port, trap entry (ecall) / trap return (mret) updates of mstatus/mepc, and
// the 64-bit mcycle / minstret counters. mtvec and mepc are exported for
// next-PC redirects.
// Ports:
//   clk    core clock, all state updates on posedge
//   rst_n  asynchronous active-low reset
//   bus    csr_file_if.slave (see csr_file_if for signal list)
// Parameters:
//   MVENDORID_VAL  read-only value at 0xF11
//   MARCHID_VAL    read-only value at 0xF12
// -----------------------------------------------------------------------------
module csr_file #(
    parameter logic [31:0] MVENDORID_VAL = 32'h0,
    parameter logic [31:0] MARCHID_VAL   = 32'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    csr_file_if.slave        bus
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;

    // Architectural state. mstatus keeps only MIE/MPIE; MPP is hardwired to M.
    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    // Qualified update strobes; nothing but mcycle moves without retire.
    logic w_wr;
    logic w_trap;
    logic w_mret;
    logic w_wr_mstatus;
    logic w_wr_mtvec;
    logic w_wr_mscratch;
    logic w_wr_mepc;
    logic w_wr_mcause;
    logic w_wr_mcycle;
    logic w_wr_mcycleh;
    logic w_wr_minstret;
    logic w_wr_minstreth;
    logic [31:0] w_mstatus;
    logic [31:0] w_wdata_al;
    logic [31:0] w_pc_al;

    assign w_wr   = bus.retire & bus.csr_wen1;
    assign w_trap = bus.retire & bus.csr_wen2;
    // Trap entry wins if both are asserted.
    assign w_mret = bus.retire & bus.mret & ~bus.csr_wen2;

    assign w_wr_mstatus   = w_wr & (bus.csr_waddr1 == A_MSTATUS);
    assign w_wr_mtvec     = w_wr & (bus.csr_waddr1 == A_MTVEC);
    assign w_wr_mscratch  = w_wr & (bus.csr_waddr1 == A_MSCRATCH);
    assign w_wr_mepc      = w_wr & (bus.csr_waddr1 == A_MEPC);
    assign w_wr_mcause    = w_wr & (bus.csr_waddr1 == A_MCAUSE);
    assign w_wr_mcycle    = w_wr & (bus.csr_waddr1 == A_MCYCLE);
    assign w_wr_mcycleh   = w_wr & (bus.csr_waddr1 == A_MCYCLEH);
    assign w_wr_minstret  = w_wr & (bus.csr_waddr1 == A_MINSTRET);
    assign w_wr_minstreth = w_wr & (bus.csr_waddr1 == A_MINSTRETH);

    // mtvec (direct mode only) and mepc are word aligned.
    assign w_wdata_al = bus.csr_wdata1 & 32'hFFFF_FFFC;
    assign w_pc_al    = bus.pc & 32'hFFFF_FFFC;

    assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie  <= 1'b0;
            r_mpie <= 1'b0;
        end else if (w_trap) begin
            r_mpie <= r_mie;
            r_mie  <= 1'b0;
        end else if (w_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wr_mstatus) begin
            r_mie  <= bus.csr_wdata1[3];
            r_mpie <= bus.csr_wdata1[7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mepc <= 32'd0;
        end else if (w_trap) begin
            r_mepc <= w_pc_al;
        end else if (w_wr_mepc) begin
            r_mepc <= w_wdata_al;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtvec    <= 32'd0;
            r_mscratch <= 32'd0;
            r_mcause   <= 32'd0;
        end else begin
            if (w_wr_mtvec)    r_mtvec    <= w_wdata_al;
            if (w_wr_mscratch) r_mscratch <= bus.csr_wdata1;
            if (w_wr_mcause)   r_mcause   <= bus.csr_wdata1;
        end
    end

    // Counters: a write to either half replaces that half and suppresses the
    // increment; otherwise a full 64-bit add carries across the halves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle <= 64'd0;
        end else if (w_wr_mcycle) begin
            r_mcycle[31:0] <= bus.csr_wdata1;
        end else if (w_wr_mcycleh) begin
            r_mcycle[63:32] <= bus.csr_wdata1;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_minstret <= 64'd0;
        end else if (w_wr_minstret) begin
            r_minstret[31:0] <= bus.csr_wdata1;
        end else if (w_wr_minstreth) begin
            r_minstret[63:32] <= bus.csr_wdata1;
        end else if (bus.retire) begin
            r_minstret <= r_minstret + 64'd1;
        end
    end

    // Read port is purely combinational from the registers, so a read in the
    // same cycle as a write naturally returns the old value.
    // NOTE: csr_rdata gets a default before the case so no latch is inferred
    // for unmapped addresses.
    always_comb begin
        bus.csr_rdata = 32'd0;
        case (bus.csr_raddr)
            A_MSTATUS:   bus.csr_rdata = w_mstatus;
            A_MTVEC:     bus.csr_rdata = r_mtvec;
            A_MSCRATCH:  bus.csr_rdata = r_mscratch;
            A_MEPC:      bus.csr_rdata = r_mepc;
            A_MCAUSE:    bus.csr_rdata = r_mcause;
            A_MCYCLE:    bus.csr_rdata = r_mcycle[31:0];
            A_MINSTRET:  bus.csr_rdata = r_minstret[31:0];
            A_MCYCLEH:   bus.csr_rdata = r_mcycle[63:32];
            A_MINSTRETH: bus.csr_rdata = r_minstret[63:32];
            A_MVENDORID: bus.csr_rdata = MVENDORID_VAL;
            A_MARCHID:   bus.csr_rdata = MARCHID_VAL;
            default:     bus.csr_rdata = 32'd0;
        endcase
    end

    assign bus.mtvec_o = r_mtvec;
    assign bus.mepc_o  = r_mepc;

endmodule

// File: tb/tb_csr_file.sv
// -----------------------------------------------------------------------------
// tb_csr_file
// Self-checking bench for csr_file: a vector table for register/trap
// behaviour, then hand-written sequences for counters and async reset.
// -----------------------------------------------------------------------------
module tb_csr_file;

    localparam logic [31:0] VEND = 32'h0000_0602;
    localparam logic [31:0] ARCH = 32'h0000_0019;
    localparam logic [31:0] MT   = 32'h8000_0100;
    localparam int          NV   = 34;

    logic clk;
    logic rst_n;

    csr_file_if u_if ();

    csr_file #(
        .MVENDORID_VAL (VEND),
        .MARCHID_VAL   (ARCH)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        retire;
        logic        wen1;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        wen2;
        logic        mret;
        logic [31:0] pc;
        logic [11:0] raddr;
        logic [31:0] exp_rdata;
        logic [31:0] exp_mtvec;
        logic [31:0] exp_mepc;
    } vec_t;

    typedef struct {
        string       name;
        logic        chk_ptrs;
        logic [31:0] exp_rdata;
        logic [31:0] exp_mtvec;
        logic [31:0] exp_mepc;
    } sb_t;

    vec_t vecs [NV];
    sb_t  sb [$];
    int   n_cmp;
    int   n_bad;

    function automatic vec_t mk(input logic r, input logic w1, input logic [11:0] wa,
                                input logic [31:0] wd, input logic w2, input logic m,
                                input logic [31:0] p, input logic [11:0] ra,
                                input logic [31:0] er, input logic [31:0] emt,
                                input logic [31:0] emp);
        vec_t v;
        v.retire = r;   v.wen1 = w1;  v.waddr = wa;  v.wdata = wd;
        v.wen2 = w2;    v.mret = m;   v.pc = p;      v.raddr = ra;
        v.exp_rdata = er; v.exp_mtvec = emt; v.exp_mepc = emp;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the negedge, queue the expectation, and
    // compare once the combinational outputs have settled (before posedge).
    task automatic step(input logic r, input logic w1, input logic [11:0] wa,
                        input logic [31:0] wd, input logic w2, input logic m,
                        input logic [31:0] p, input logic [11:0] ra,
                        input logic do_chk, input logic chk_ptrs,
                        input logic [31:0] er, input logic [31:0] emt,
                        input logic [31:0] emp, input string nm);
        sb_t e;
        @(negedge clk);
        u_if.retire     = r;
        u_if.csr_wen1   = w1;
        u_if.csr_waddr1 = wa;
        u_if.csr_wdata1 = wd;
        u_if.csr_wen2   = w2;
        u_if.mret       = m;
        u_if.pc         = p;
        u_if.csr_raddr  = ra;
        if (do_chk) sb.push_back('{nm, chk_ptrs, er, emt, emp});
        #1;
        if (do_chk) begin
            if (sb.size() == 0) begin
                check({nm, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_rdata"}, u_if.csr_rdata, e.exp_rdata);
                if (e.chk_ptrs) begin
                    check({e.name, "_mtvec_o"}, u_if.mtvec_o, e.exp_mtvec);
                    check({e.name, "_mepc_o"},  u_if.mepc_o,  e.exp_mepc);
                end
            end
        end
    endtask

    // Read-only cycle with rdata check.
    task automatic rd(input logic [11:0] ra, input logic [31:0] er, input string nm);
        step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, ra, 1'b1, 1'b0, er, 32'h0, 32'h0, nm);
    endtask

    // Retiring port-1 write with no check.
    task automatic wr(input logic [11:0] wa, input logic [31:0] wd);
        step(1'b1, 1'b1, wa, wd, 1'b0, 1'b0, 32'h0, 12'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, "");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        u_if.retire = 1'b0; u_if.csr_wen1 = 1'b0; u_if.csr_waddr1 = 12'h0;
        u_if.csr_wdata1 = 32'h0; u_if.csr_wen2 = 1'b0; u_if.mret = 1'b0;
        u_if.pc = 32'h0; u_if.csr_raddr = 12'h300;

        //            r  w1 waddr   wdata         w2 m  pc            raddr   exp_rdata     mtvec  mepc
        vecs[0]  = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h300, 32'h0000_1800, 32'h0, 32'h0);
        vecs[1]  = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h305, 32'h0,         32'h0, 32'h0);
        vecs[2]  = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h341, 32'h0,         32'h0, 32'h0);
        vecs[3]  = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h342, 32'h0,         32'h0, 32'h0);
        vecs[4]  = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'hF11, VEND,          32'h0, 32'h0);
        vecs[5]  = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'hF12, ARCH,          32'h0, 32'h0);
        vecs[6]  = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h123, 32'h0,         32'h0, 32'h0);
        // csrrw mtvec: same-cycle read returns old value; WARL clears [1:0]
        vecs[7]  = mk(1, 1, 12'h305, 32'h8000_0103, 0, 0, 32'h0,       12'h305, 32'h0,         32'h0, 32'h0);
        vecs[8]  = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h305, MT,            MT,    32'h0);
        // mstatus write of all-ones except MPIE -> only MIE sticks
        vecs[9]  = mk(1, 1, 12'h300, 32'hFFFF_FF7F, 0, 0, 32'h0,       12'h300, 32'h0000_1800, MT,    32'h0);
        // ecall with same-cycle mcause write
        vecs[10] = mk(1, 1, 12'h342, 32'd11,       1, 0, 32'h8000_0040, 12'h300, 32'h0000_1808, MT,    32'h0);
        vecs[11] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h341, 32'h8000_0040, MT,    32'h8000_0040);
        vecs[12] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h342, 32'd11,        MT,    32'h8000_0040);
        vecs[13] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h300, 32'h0000_1880, MT,    32'h8000_0040);
        // mret
        vecs[14] = mk(1, 0, 12'h000, 32'h0,        0, 1, 32'h0,        12'h300, 32'h0000_1880, MT,    32'h8000_0040);
        vecs[15] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h300, 32'h0000_1888, MT,    32'h8000_0040);
        // write without retire is ignored
        vecs[16] = mk(0, 1, 12'h340, 32'hDEAD_BEEF, 0, 0, 32'h0,       12'h340, 32'h0,         MT,    32'h8000_0040);
        vecs[17] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h340, 32'h0,         MT,    32'h8000_0040);
        vecs[18] = mk(1, 1, 12'h340, 32'hDEAD_BEEF, 0, 0, 32'h0,       12'h340, 32'h0,         MT,    32'h8000_0040);
        vecs[19] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h340, 32'hDEAD_BEEF, MT,    32'h8000_0040);
        // mepc WARL
        vecs[20] = mk(1, 1, 12'h341, 32'h1234_5677, 0, 0, 32'h0,       12'h341, 32'h8000_0040, MT,    32'h8000_0040);
        vecs[21] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h341, 32'h1234_5674, MT,    32'h1234_5674);
        // trap entry beats port-1 write to mepc
        vecs[22] = mk(1, 1, 12'h341, 32'hAAAA_AAA8, 1, 0, 32'h0000_0200, 12'h341, 32'h1234_5674, MT,  32'h1234_5674);
        vecs[23] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h341, 32'h0000_0200, MT,    32'h0000_0200);
        // trap entry beats port-1 write to mstatus (0x1888 -> 0x1880 -> 0x1800)
        vecs[24] = mk(1, 1, 12'h300, 32'h0000_0008, 1, 0, 32'h0000_0300, 12'h300, 32'h0000_1880, MT, 32'h0000_0200);
        vecs[25] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h300, 32'h0000_1800, MT,    32'h0000_0300);
        // wen2 with mret: trap entry wins (mret alone would give 0x1880)
        vecs[26] = mk(1, 0, 12'h000, 32'h0,        1, 1, 32'h0000_0400, 12'h300, 32'h0000_1800, MT,   32'h0000_0300);
        vecs[27] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h341, 32'h0000_0400, MT,    32'h0000_0400);
        vecs[28] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h300, 32'h0000_1800, MT,    32'h0000_0400);
        // read-only and unmapped writes ignored
        vecs[29] = mk(1, 1, 12'hF11, 32'h0000_FFFF, 0, 0, 32'h0,       12'hF11, VEND,          MT,    32'h0000_0400);
        vecs[30] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'hF11, VEND,          MT,    32'h0000_0400);
        vecs[31] = mk(1, 1, 12'h7C0, 32'h0000_0055, 0, 0, 32'h0,       12'h7C0, 32'h0,         MT,    32'h0000_0400);
        vecs[32] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h7C0, 32'h0,         MT,    32'h0000_0400);
        vecs[33] = mk(0, 0, 12'h000, 32'h0,        0, 0, 32'h0,        12'h305, MT,            MT,    32'h0000_0400);

        repeat (3) @(negedge clk);
        #1;
        check("in_reset_mstatus", u_if.csr_rdata, 32'h0000_1800);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].retire, vecs[i].wen1, vecs[i].waddr, vecs[i].wdata,
                 vecs[i].wen2, vecs[i].mret, vecs[i].pc, vecs[i].raddr,
                 1'b1, 1'b1, vecs[i].exp_rdata, vecs[i].exp_mtvec, vecs[i].exp_mepc,
                 $sformatf("row%0d", i));
        end

        // mcycle low-word carry (high word is still 0 this early)
        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle_lo_set");
        rd(12'hB00, 32'h0,         "mcycle_lo_wrap");
        rd(12'hB80, 32'h1,         "mcycleh_carry");
        // mcycle 64-bit wrap
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFE);
        rd(12'hB00, 32'hFFFF_FFFE, "mcycle_lo_hold");
        rd(12'hB80, 32'hFFFF_FFFF, "mcycleh_max");
        rd(12'hB80, 32'h0,         "mcycleh_wrap");
        rd(12'hB00, 32'h1,         "mcycle_after_wrap");

        // minstret: clear, then 10 cycles with 5 retiring
        wr(12'hB82, 32'h0);
        wr(12'hB02, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step((i % 2) == 0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 12'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, "");
        end
        rd(12'hB02, 32'd5, "minstret_count");
        rd(12'hB82, 32'd0, "minstreth_count");
        step(1'b1, 1'b1, 12'hF12, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 12'hF12,
             1'b1, 1'b0, ARCH, 32'h0, 32'h0, "marchid_wr_same");
        rd(12'hF12, ARCH,  "marchid_ro");
        rd(12'hB02, 32'd6, "minstret_after_ro_wr");
        step(1'b1, 1'b1, 12'hB02, 32'h10, 1'b0, 1'b0, 32'h0, 12'hB02,
             1'b1, 1'b0, 32'd6, 32'h0, 32'h0, "minstret_wr_old");
        rd(12'hB02, 32'h10, "minstret_wr_new");
        step(1'b1, 1'b1, 12'hB82, 32'h7, 1'b0, 1'b0, 32'h0, 12'hB02,
             1'b1, 1'b0, 32'h10, 32'h0, 32'h0, "minstreth_wr_cycle");
        rd(12'hB02, 32'h10, "minstret_hi_wr_no_inc");
        rd(12'hB82, 32'h7,  "minstreth_wr_new");
        // minstret low-word carry on a retiring cycle
        wr(12'hB82, 32'h0);
        wr(12'hB02, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 12'hB02,
             1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, "minstret_lo_max");
        rd(12'hB82, 32'h1, "minstreth_carry");
        rd(12'hB02, 32'h0, "minstret_lo_wrap");

        // async reset mid-cycle with a write in flight
        wr(12'h340, 32'h0000_1111);
        rd(12'h340, 32'h0000_1111, "mscratch_pre_reset");
        @(negedge clk);
        u_if.retire = 1'b1; u_if.csr_wen1 = 1'b1;
        u_if.csr_waddr1 = 12'h340; u_if.csr_wdata1 = 32'h0000_2222;
        u_if.csr_raddr = 12'h340;
        #1 rst_n = 1'b0;
        #1 check("reset_mscratch", u_if.csr_rdata, 32'h0);
        check("reset_mtvec_o", u_if.mtvec_o, 32'h0);
        check("reset_mepc_o",  u_if.mepc_o,  32'h0);
        u_if.csr_raddr = 12'h300;
        #1 check("reset_mstatus", u_if.csr_rdata, 32'h0000_1800);
        @(negedge clk);
        u_if.retire = 1'b0; u_if.csr_wen1 = 1'b0;
        rst_n = 1'b1;
        rd(12'h340, 32'h0, "write_lost_in_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
